// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, data width
// and default bit period. Optional parity support is selected by the
// UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial input, byte handshake and status pulses of the UART receiver.
// rx_parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic              rx;
  logic              rx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_busy;
  logic              rx_frame_err;
  logic              rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic              rx_parity_err;
`endif

  // Receiver side
  modport slave (
    input  rx, rx_ready,
    output rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun
`ifdef UART_RX_PARITY_EN
    , output rx_parity_err
`endif
  );

  // Line driver / byte consumer side
  modport master (
    output rx, rx_ready,
    input  rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun
`ifdef UART_RX_PARITY_EN
    , input rx_parity_err
`endif
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so
// the line reads as idle while reset is asserted.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  // Shift the raw line through two flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver with valid/ready holding register, frame-error and
// overrun pulses. Defining UART_RX_PARITY_EN adds an even-parity bit
// between data and stop, plus the rx_parity_err pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input logic           rx_clk,
  input logic           reset,
  uart_rx_core_if.slave bus
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  // The edge-detect cycle already counts toward the half-bit delay
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic              w_rx_s;
  rx_state_e         r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [2:0]        r_bit, w_bit_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_done, w_done_next;
  logic              r_frame_err, w_frame_err_next;
  logic [1:0]        r_settle;
  logic              r_rx_prev;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_overrun;
  logic              w_tick;
  logic              w_hs;
`ifdef UART_RX_PARITY_EN
  logic              r_par_bad, w_par_bad_next;
  logic              r_parity_err, w_parity_err_next;
`endif

  uart_sync2 u_sync (
    .i_clk (rx_clk),
    .i_rst (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  assign w_tick = (r_cnt == FULL_M1);
  assign w_hs   = r_valid & bus.rx_ready;

  // Previous synchronized level; held low until the synchronizer has
  // refilled after reset, so a line stuck low never looks like a start edge
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      r_settle  <= 2'd0;
      r_rx_prev <= 1'b0;
    end else begin
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      r_rx_prev <= (r_settle == 2'd2) ? w_rx_s : 1'b0;
    end
  end

  // FSM state, bit timing and shift register
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_done      <= w_done_next;
      r_frame_err <= w_frame_err_next;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad_next;
      r_parity_err <= w_parity_err_next;
`endif
    end
  end

  // Next-state logic: half-bit wait in START, full-bit samples afterwards
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + CNT_ONE;
    w_bit_next       = r_bit;
    w_shift_next     = r_shift;
    w_done_next      = 1'b0;
    w_frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next    = r_par_bad;
    w_parity_err_next = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (r_rx_prev && !w_rx_s) begin
          w_state_next = ST_START;
          w_cnt_next   = CNT_ONE;
          w_bit_next   = '0;
`ifdef UART_RX_PARITY_EN
          w_par_bad_next = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next   = '0;
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx_s, r_shift[DATA_W-1:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_cnt_next   = '0;
          w_state_next = ST_STOP;
          if (^{r_shift, w_rx_s}) begin
            w_par_bad_next    = 1'b1;
            w_parity_err_next = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_state_next = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_done_next  = !r_par_bad;
`else
            w_done_next  = 1'b1;
`endif
          end else begin
            w_state_next     = ST_BREAK;
            w_frame_err_next = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        w_cnt_next = '0;
        if (w_rx_s) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Holding register: load when empty or being consumed, else drop and flag
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || w_hs) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_valid     = r_valid;
  assign bus.rx_data      = r_data;
  assign bus.rx_busy      = (r_state != ST_IDLE);
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: bytes expected to be consumed are
// queued by the stimulus; a negedge monitor pops them on each handshake.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int GAP = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 2 + CPB/2 + 10*CPB + 1;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 2 + CPB/2 + 9*CPB + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_core_if bus();

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tf       = 0;
  int t_rise   = 0;
  int rise_cnt = 0;
  int vhi_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  logic [7:0] q[$];
  logic       m_pv  = 1'b0;
  logic       m_phs = 1'b0;
  logic [7:0] m_pd  = 8'h00;
  bit         rnd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; pulses and valid rises counted
  always @(negedge clk) begin
    if (rst) begin
      m_pv  = 1'b0;
      m_phs = 1'b0;
    end else begin
      if (bus.rx_valid && !m_pv) begin
        rise_cnt++;
        t_rise = cyc;
      end
      if (bus.rx_valid) vhi_cnt++;
      if (m_pv && !m_phs) begin
        chk("valid_hold", {31'd0, bus.rx_valid}, 32'd1);
        chk("data_stable", {24'd0, bus.rx_data}, {24'd0, m_pd});
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", bus.rx_data, cyc);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          $display("txn: byte 0x%02h consumed at cycle %0d (expected 0x%02h)", bus.rx_data, cyc, e);
          chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e});
        end
      end
      if (bus.rx_frame_err) ferr_cnt++;
      if (bus.rx_overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (bus.rx_parity_err) perr_cnt++;
`endif
      m_pv  = bus.rx_valid;
      m_phs = bus.rx_valid && bus.rx_ready;
      m_pd  = bus.rx_data;
    end
  end

  // Drive the first nb bits of a frame; the line is left at the last bit
  task automatic send_bits(input logic [7:0] d, input logic stop_b, input logic par_b, input int nb);
    logic [10:0] b;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UART_RX_PARITY_EN
    b[9]  = par_b;
    b[10] = stop_b;
`else
    b[9]  = stop_b;
    b[10] = par_b;
`endif
    @(posedge clk); #1;
    tf = cyc;
    for (int i = 0; i < nb; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_line(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A well-formed frame whose byte is expected to be consumed
  task automatic good(input logic [7:0] d);
    q.push_back(d);
    $display("txn: send 0x%02h", d);
    send_bits(d, 1'b1, ^d, NBITS);
    idle_line(GAP);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    chk({tag, "_data"},  {24'd0, bus.rx_data}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.rx_busy}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, bus.rx_frame_err}, 32'd0);
    chk({tag, "_ovr"},   {31'd0, bus.rx_overrun}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_perr"},  {31'd0, bus.rx_parity_err}, 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, o0, p0, v0, bsy, exp_ferr;
    logic [7:0] d;
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_values("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single byte, consumer always ready: latency and one-cycle valid
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhi_cnt;
    good(8'hA5);
    chk("a5_rises", rise_cnt - r0, 1);
    chk("a5_latency", t_rise - tf, LAT);
    chk("a5_valid_width", vhi_cnt - v0, 1);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_ovr", ovr_cnt - o0, 0);

    // Short low glitch is a false start
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy", {31'd0, bus.rx_busy}, 32'd1);
    idle_line(3*CPB);
    $display("txn: glitch done");
    chk("glitch_rises", rise_cnt - r0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_ovr", ovr_cnt - o0, 0);
    chk("glitch_perr", perr_cnt - p0, 0);
    chk("glitch_idle", {31'd0, bus.rx_busy}, 32'd0);

    // Bad stop bit, then a long break, then recovery
    r0 = rise_cnt; f0 = ferr_cnt;
    $display("txn: send 0x3c with stop=0 and break");
    send_bits(8'h3C, 1'b0, ^8'h3C, NBITS);
    bus.rx = 1'b0;
    repeat (40*CPB) @(posedge clk);
    #1;
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_busy", {31'd0, bus.rx_busy}, 32'd1);
    idle_line(CPB);
    good(8'h55);
    chk("break_ferr_total", ferr_cnt - f0, 1);
    chk("break_rises", rise_cnt - r0, 1);

    // Overrun: second byte dropped while the first waits
    o0 = ovr_cnt;
    bus.rx_ready = 1'b0;
    good(8'h11);
    $display("txn: send 0x22 (expected dropped)");
    send_bits(8'h22, 1'b1, ^8'h22, NBITS);
    idle_line(GAP);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("ovr_data", {24'd0, bus.rx_data}, 32'h11);
    bus.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    chk("ovr_cleared", {31'd0, bus.rx_valid}, 32'd0);

    // Handshake lands on the exact load cycle of the next byte
    o0 = ovr_cnt;
    good(8'h11);
    q.push_back(8'h22);
    $display("txn: send 0x22 with same-cycle handshake");
    fork
      begin
        send_bits(8'h22, 1'b1, ^8'h22, NBITS);
        idle_line(GAP);
      end
      begin
        int t0;
        @(posedge clk); #1;
        t0 = cyc;
        repeat (LAT - 1) @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        chk("same_cycle_t", cyc - t0, LAT);
      end
    join
    chk("same_cycle_ovr", ovr_cnt - o0, 0);
    chk("same_cycle_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("same_cycle_data", {24'd0, bus.rx_data}, 32'h22);
    bus.rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("same_cycle_drained", {31'd0, bus.rx_valid}, 32'd0);

    // Reset in the middle of DATA with the line then held low
    $display("txn: send 0x0f interrupted by reset");
    send_bits(8'h0F, 1'b1, ^8'h0F, 4);
    bus.rx = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bsy = 0;
    repeat (3*CPB) begin
      @(posedge clk); #1;
      bsy = bsy | int'(bus.rx_busy);
    end
    chk("no_start_after_reset", bsy, 0);
    idle_line(CPB);
    r0 = rise_cnt;
    good(8'hF0);
    chk("after_reset_rises", rise_cnt - r0, 1);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit drops the byte
    r0 = rise_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    $display("txn: send 0x01 with bad parity");
    send_bits(8'h01, 1'b1, 1'b0, NBITS);
    idle_line(GAP);
    chk("par_perr", perr_cnt - p0, 1);
    chk("par_rises", rise_cnt - r0, 0);
    chk("par_ferr", ferr_cnt - f0, 0);
    good(8'h5A);
    chk("par_recover_rises", rise_cnt - r0, 1);
`endif

    // Random bytes, random stop errors, random consumer readiness
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_ferr = 0;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          bus.rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        exp_ferr++;
        $display("txn: send 0x%02h with stop=0", d);
        send_bits(d, 1'b0, ^d, NBITS);
        idle_line(GAP + CPB);
      end else begin
        good(d);
      end
    end
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    bus.rx_ready = 1'b1;
    for (int w = 0; w < 200 && q.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_ferr", ferr_cnt - f0, exp_ferr);
    chk("rnd_ovr", ovr_cnt - o0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("final_valid", {31'd0, bus.rx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 CLKS_PER_BIT, default 16, SHALL set the rx_clk cycles per serial bit; legal values are even and at least 4.
REQ-003 rx_clk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous active-high reset.
REQ-005 rx  in  1  SHALL be the serial line (idle high, 8N1 LSB-first frame, same format tx_core emits), asynchronous to rx_clk.
REQ-006 rx_ready  in  1  SHALL mean the downstream consumer accepts rx_data this cycle.
REQ-007 rx_valid  out  1  SHALL mean rx_data holds an unconsumed byte.
REQ-008 rx_data  out  8  SHALL be the received byte, stable while rx_valid=1.
REQ-009 rx_busy  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 rx_frame_err  out  1  SHALL be a one-cycle pulse on a bad stop bit.
REQ-011 rx_overrun  out  1  SHALL be a one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK, plus PARITY when parity is enabled.
REQ-014 IDLE->START SHALL occur on a 1-to-0 transition of rx_s; the bit counter clears.
REQ-015 START SHALL sample rx_s after CLKS_PER_BIT/2 cycles: 0 -> DATA; 1 -> IDLE (false start, no output, no error).
REQ-016 DATA SHALL sample every CLKS_PER_BIT cycles, shift 8 bits LSB first, then go to STOP, or PARITY if enabled.
REQ-017 STOP SHALL sample at mid-bit: 1 -> byte complete, go to IDLE; 0 -> pulse rx_frame_err, discard byte, go to BREAK.
REQ-018 BREAK SHALL remain until rx_s=1, then go to IDLE; no new frame starts in BREAK.
REQ-019 A completed byte SHALL load rx_data and set rx_valid on the cycle after the stop sample.
REQ-020 A valid/ready handshake SHALL occur when rx_valid and rx_ready are both 1; rx_valid clears next cycle unless a new byte loads in that same cycle.
REQ-021 If a byte completes while rx_valid=1 and rx_ready=0, the byte SHALL be dropped, the old rx_data kept, and rx_overrun pulsed.
REQ-022 A byte completing in the same cycle as a handshake SHALL load, keep rx_valid=1, and raise no overrun.
REQ-023 End-to-end latency SHALL be 155 cycles (CLKS_PER_BIT=16) from the rx falling edge to rx_valid rising: 2 synchronizer + 8 + 9x16 + 1.
REQ-024 rx_ready SHALL have no effect while rx_valid=0.

Reset
REQ-025 On reset assertion, asynchronously: FSM=IDLE, counters=0, synchronizer flops=1, rx_valid=0, rx_data=0x00, rx_busy=0, rx_frame_err=0, rx_overrun=0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh falling edge and SHALL NOT treat a line held low as a start bit.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, the block SHALL add the PARITY state and check even parity at mid-bit.
REQ-028 With UART_RX_PARITY_EN defined, the block SHALL add output rx_parity_err (1-bit pulse); a parity failure pulses it and discards the byte.
REQ-029 With UART_RX_PARITY_EN defined, frame latency SHALL grow by CLKS_PER_BIT.
REQ-030 Without UART_RX_PARITY_EN, there SHALL be no PARITY state and no rx_parity_err port.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding, the data width constant (8), and the default CLKS_PER_BIT.
REQ-032 Sub-module uart_sync2 SHALL implement the 2-flop synchronizer with reset value 1; all other logic stays in uart_rx_core.

Verification
REQ-033 Send 0xA5 and hold rx_ready=1 -> rx_valid pulses one cycle 155 cycles after the falling edge, with rx_data=0xA5 and no errors.
REQ-034 Send a 4-cycle low glitch on rx -> START returns to IDLE, rx_valid stays 0, no error pulses.
REQ-035 Send 0x3C with the stop bit driven 0, then hold the line low for 40 bit times -> exactly one rx_frame_err pulse, no rx_valid, and the next 0x55 frame after the line goes high is received correctly.
REQ-036 Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data remains 0x11, one rx_overrun pulse; then rx_ready=1 -> handshake, rx_valid clears.
REQ-037 Time the handshake of 0x11 to the exact completion cycle of 0x22 -> rx_valid stays 1, rx_data=0x22, no overrun.
REQ-038 Assert reset in the middle of DATA of 0x0F -> outputs go to reset values immediately, and the following frame 0xF0 is received correctly; with UART_RX_PARITY_EN, a 0x01 frame with parity bit 0 -> rx_parity_err pulse and no rx_valid.
